// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its request arbiter:
// ALU control codes and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_NOR = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unknown control codes yield zero, which is a
// normal result rather than an error.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  input  logic [3:0]  ctrl_i,
  output logic [31:0] out_o,
  output logic        zero_o
);

  always_comb begin
    out_o = 32'd0;
    case (ctrl_i)
      ALU_AND: out_o = in1_i & in2_i;
      ALU_OR:  out_o = in1_i | in2_i;
      ALU_ADD: out_o = in1_i + in2_i;
      ALU_SUB: out_o = in1_i - in2_i;
      ALU_SLT: out_o = ($signed(in1_i) < $signed(in2_i)) ? 32'd1 : 32'd0;
      ALU_NOR: out_o = ~(in1_i | in2_i);
      ALU_XOR: out_o = in1_i ^ in2_i;
      default: out_o = 32'd0;
    endcase
  end

  assign zero_o = (out_o == 32'd0);

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: scans from ptr_i upward (mod NREQ) and returns the first
// valid requester as a one-hot grant plus its encoded index.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters: round-robin grant in IDLE, one
// registered execute cycle, then a tagged response held until accepted.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int CNTW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_in1,
  input  logic [NREQ*32-1:0] req_in2,
  input  logic [NREQ*4-1:0]  req_ctrl,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_out,
  output logic               rsp_zero,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy,
  output logic [CNTW-1:0]    ops_done
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]     in1_q, in2_q;
  logic [3:0]      ctrl_q;
  logic [IDW-1:0]  id_q;
  logic [31:0]     rsp_out_q;
  logic            rsp_zero_q;
  logic [IDW-1:0]  rsp_id_q;
  logic            rsp_valid_q;
  logic [CNTW-1:0] ops_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            any_valid;
  logic [31:0]     alu_out;
  logic            alu_zero;
  logic            accept;

  logic [31:0] in1_arr  [NREQ];
  logic [31:0] in2_arr  [NREQ];
  logic [3:0]  ctrl_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign in1_arr[gi]  = req_in1[gi*32 +: 32];
      assign in2_arr[gi]  = req_in2[gi*32 +: 32];
      assign ctrl_arr[gi] = req_ctrl[gi*4 +: 4];
    end
  endgenerate

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_valid)
  );

  // The ALU only ever sees the captured operands, never the live request bus.
  alu u_alu (
    .in1_i  (in1_q),
    .in2_i  (in2_q),
    .ctrl_i (ctrl_q),
    .out_o  (alu_out),
    .zero_o (alu_zero)
  );

  assign accept   = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;
  assign rr_ptr_d = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) ? grant : '0;
    busy      = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      ctrl_q      <= '0;
      id_q        <= '0;
      rsp_out_q   <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      ops_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            in1_q  <= in1_arr[win_idx];
            in2_q  <= in2_arr[win_idx];
            ctrl_q <= ctrl_arr[win_idx];
            id_q   <= win_idx;
          end
        end
        ST_EXEC: begin
          rsp_out_q   <= alu_out;
          rsp_zero_q  <= alu_zero;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          if (accept) begin
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= rr_ptr_d;
            ops_q       <= ops_q + CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and a 4-bit op counter
// so that counter wrap is reachable in a short run.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int CNTW = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_in1;
  logic [NREQ*32-1:0] req_in2;
  logic [NREQ*4-1:0]  req_ctrl;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_out;
  logic               rsp_zero;
  logic [IDW-1:0]     rsp_id;
  logic               busy;
  logic [CNTW-1:0]    ops_done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CNTW-1:0] ops_model = '0;

  alu_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_zero  (rsp_zero),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    ops_model = '0;
  endtask

  // One complete op from requester id with rsp_ready held high.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic [31:0] expv, input string tag);
    int n;
    req_in1[id*32 +: 32] = a;
    req_in2[id*32 +: 32] = b;
    req_ctrl[id*4 +: 4]  = c;
    req_valid[id]        = 1'b1;
    rsp_ready            = 1'b1;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(1 << id));
    tick();
    check({tag, "_pulse"}, 32'(req_ready), 32'd0);
    req_valid[id]        = 1'b0;
    req_in1[id*32 +: 32] = ~a;
    req_ctrl[id*4 +: 4]  = ~c;
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_out"}, rsp_out, expv);
    check({tag, "_zero"}, 32'(rsp_zero), 32'(expv == 32'd0));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    tick();
    ops_model = ops_model + 1'b1;
    check({tag, "_ops"}, 32'(ops_done), 32'(ops_model));
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
    $display("op %s id=%0d ctrl=%0d a=%h b=%h result=%h", tag, id, c, a, b, expv);
  endtask

  initial begin
    req_in1  = '0;
    req_in2  = '0;
    req_ctrl = '0;
    do_reset();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_out", rsp_out, 32'd0);
    check("rst_zero", 32'(rsp_zero), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_ops", 32'(ops_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    issue(0, 32'd5, 32'd10, 4'd1, 32'd0, "and0");

    // Fairness with both requesters continuously valid.
    do_reset();
    req_in1   = {32'd100, 32'd7};
    req_in2   = {32'hFFFF_FFFF, 32'd8};
    req_ctrl  = {4'd3, 4'd3};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int r = 0; r < 4; r++) begin
      int n;
      n = 0;
      while (req_ready === 2'b00 && n < 20) begin
        tick();
        n++;
      end
      check("fair_grant", 32'(req_ready), (r % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      tick();
      check("fair_id", 32'(rsp_id), 32'(r % 2));
      check("fair_out", rsp_out, (r % 2 == 0) ? 32'd15 : 32'd99);
      tick();
      ops_model = ops_model + 1'b1;
      $display("op fair%0d id=%0d result=%h", r, r % 2, rsp_out);
    end
    check("fair_ops", 32'(ops_done), 32'd4);
    req_valid = 2'b00;
    tick();

    // Backpressure: response must hold and no new grant while stalled.
    rsp_ready            = 1'b0;
    req_in1[31:0]        = 32'd3;
    req_in2[31:0]        = 32'd5;
    req_ctrl[3:0]        = 4'd4;
    req_valid            = 2'b01;
    #1;
    begin
      int n;
      n = 0;
      while (req_ready[0] !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
    end
    check("bp_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b11;
    tick();
    for (int s = 0; s < 5; s++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_out", rsp_out, 32'hFFFF_FFFE);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    ops_model = ops_model + 1'b1;
    check("bp_ops", 32'(ops_done), 32'(ops_model));
    check("bp_next", 32'(req_ready), 32'd2);
    $display("op backpressure id=0 result=fffffffe");
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    tick();

    issue(1, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1, "slt");
    issue(0, 32'd1, 32'hFFFF_FFFF, 4'd5, 32'd0, "slt_f");
    issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd9, 32'd0, "bad9");
    issue(0, 32'h0000_00F0, 32'h0000_000F, 4'd2, 32'h0000_00FF, "or");
    issue(1, 32'h0000_0000, 32'h0000_0000, 4'd6, 32'hFFFF_FFFF, "nor");
    issue(0, 32'h0000_00FF, 32'h0000_000F, 4'd7, 32'h0000_00F0, "xor");
    issue(1, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'd1, 32'h0F0F_0F0F, "and1");

    // Reset while the op is in EXEC.
    req_in1[31:0] = 32'd1;
    req_in2[31:0] = 32'd2;
    req_ctrl[3:0] = 4'd3;
    req_valid     = 2'b01;
    #1;
    begin
      int n;
      n = 0;
      while (req_ready[0] !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
    end
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    rst       = 1'b0;
    ops_model = '0;
    check("mid_busy0", 32'(busy), 32'd0);
    check("mid_valid", 32'(rsp_valid), 32'd0);
    check("mid_ops", 32'(ops_done), 32'd0);
    check("mid_out", rsp_out, 32'd0);
    req_valid = 2'b11;
    #1;
    check("mid_ptr", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    for (int s = 0; s < 4; s++) tick();
    check("mid_stale", 32'(rsp_valid), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);

    // Counter wrap: 17 ops on a 4-bit counter.
    for (int k = 0; k < 17; k++) begin
      issue(k % 2, 32'(k), 32'd1, 4'd3, 32'(k + 1), "wrap");
    end
    check("wrap_final", 32'(ops_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
